// File: rtl/adc_avg_mc_pkg.sv
// adc_avg_mc_pkg
//  Shared definitions for the multi-channel ADC averager slice: default
//  widths for the sample path, the channel tag and the averaging exponent,
//  plus the averaging-mode encoding used on i_mode.
package adc_avg_mc_pkg;

   localparam int AD_DATA_NBIT    = 12;
   localparam int AD_CHAN_NBIT    = 2;
   localparam int AD_AVG_MAX_NBIT = 4;
   localparam int AD_LOG2_NBIT    = 3;

   typedef enum logic {
      AVG_MODE_BLOCK  = 1'b0,
      AVG_MODE_MOVING = 1'b1
   } avg_mode_e;

endpackage

// File: rtl/adc_avg_hist_ram.sv
// adc_avg_hist_ram
//  Sample history for moving-average mode. Simple dual-port memory with one
//  write port and one synchronous read port (one cycle of read latency).
//  The address is {channel, pointer}. There is no reset, so the memory
//  infers as block or distributed RAM. A read of an address written in the
//  same cycle returns the old contents; the caller forwards around that.
//  Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, registered
module adc_avg_hist_ram #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/adc_avg_mc.sv
// adc_avg_mc
//  Multi-channel, runtime-configurable averager for time-multiplexed ADC
//  samples. Each channel tag keeps its own running sum, sample count and
//  history pointer. It supports block (decimating) and moving (boxcar)
//  averaging over 2^k samples, with optional round-half-up. The latency from
//  i_strobe to o_strobe is fixed at 2 cycles.
//  Ports:
//   clk, rst     clock; synchronous active-high reset
//   i_strobe     sample valid (single-cycle pulse, may repeat every cycle)
//   i_chan       channel tag of i_data
//   i_data       unsigned sample
//   i_log2_n     averaging exponent k (quasi-static; clamped to MAX_LOG2)
//   i_mode       0 = block, 1 = moving
//   i_round      1 = round half-up, 0 = truncate
//   o_strobe     average valid (single-cycle pulse)
//   o_chan       channel of o_avg_data
//   o_avg_data   averaged sample (held between strobes)
//   o_cfg_err    registered flag: i_log2_n was above MAX_LOG2
module adc_avg_mc
   import adc_avg_mc_pkg::*;
#(
   parameter int DATA_W   = AD_DATA_NBIT,
   parameter int CH_W     = AD_CHAN_NBIT,
   parameter int NCHAN    = 1 << AD_CHAN_NBIT,
   parameter int MAX_LOG2 = AD_AVG_MAX_NBIT,
   parameter int LOG2_W   = AD_LOG2_NBIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_strobe,
   input  logic [CH_W-1:0]   i_chan,
   input  logic [DATA_W-1:0] i_data,
   input  logic [LOG2_W-1:0] i_log2_n,
   input  logic              i_mode,
   input  logic              i_round,
   output logic              o_strobe,
   output logic [CH_W-1:0]   o_chan,
   output logic [DATA_W-1:0] o_avg_data,
   output logic              o_cfg_err
);

   localparam int SUM_W  = DATA_W + MAX_LOG2;
   localparam int ACC_W  = SUM_W + 1;
   localparam int CNT_W  = MAX_LOG2 + 1;
   localparam int PTR_W  = MAX_LOG2;
   localparam int ADDR_W = CH_W + PTR_W;

   function automatic logic [DATA_W-1:0] avg_of(input logic [ACC_W-1:0] s,
                                                input logic [LOG2_W-1:0] k,
                                                input logic rnd);
      logic [ACC_W-1:0] bias;
      bias = (rnd && (k != '0)) ? (ACC_W'(1) << (k - 1'b1)) : '0;
      return DATA_W'((s + bias) >> k);
   endfunction

   logic [LOG2_W-1:0] k_in, k_q;
   logic              cfg_err_in;
   avg_mode_e         mode_in, mode_q;
   logic              flush_q;
   logic [CNT_W-1:0]  n_val, n_m1;

   logic [SUM_W-1:0]  sum_r [NCHAN];
   logic [CNT_W-1:0]  cnt_r [NCHAN];
   logic [PTR_W-1:0]  ptr_r [NCHAN];

   logic              s1_valid;
   logic [CH_W-1:0]   s1_chan;
   logic [DATA_W-1:0] s1_data;
   logic [SUM_W-1:0]  s1_sum;
   logic [CNT_W-1:0]  s1_cnt;
   logic [PTR_W-1:0]  s1_ptr;
   logic              s1_hist_fwd;
   logic [DATA_W-1:0] s1_hist_data;

   logic              s2_go;
   logic              emit;
   logic [ACC_W-1:0]  sum_acc;
   logic [SUM_W-1:0]  sum_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic [PTR_W-1:0]  ptr_nx;
   logic [DATA_W-1:0] oldest;
   logic [DATA_W-1:0] avg_nx;

   logic              fwd_state;
   logic [PTR_W-1:0]  rd_ptr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr, ram_raddr;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      cfg_err_in = (i_log2_n > LOG2_W'(MAX_LOG2));
      k_in       = cfg_err_in ? LOG2_W'(MAX_LOG2) : i_log2_n;
      mode_in    = avg_mode_e'(i_mode);
      n_val      = CNT_W'(1) << k_q;
      n_m1       = n_val - 1'b1;
   end

   // The configuration registers load during reset as well, so that leaving
   // reset does not cause a spurious flush. A change in k_eff or mode raises
   // flush_q for one cycle. In that cycle all channel state is cleared, and the
   // pipeline drops both the new strobe and the sample in flight.
   always_ff @(posedge clk) begin
      k_q    <= k_in;
      mode_q <= mode_in;
      if (rst) begin
         flush_q   <= 1'b0;
         o_cfg_err <= 1'b0;
      end else begin
         flush_q   <= (k_in != k_q) || (mode_in != mode_q);
         o_cfg_err <= cfg_err_in;
      end
   end

   assign s2_go = s1_valid && !flush_q;

   // Stage 2: advance one channel's state. In moving mode, cnt counts up to N
   // (not N-1). This lets the sample that first fills the window emit without
   // subtracting a history slot that has never been written.
   always_comb begin
      sum_acc = '0;
      cnt_nx  = s1_cnt;
      ptr_nx  = s1_ptr;
      emit    = 1'b0;
      oldest  = s1_hist_fwd ? s1_hist_data : ram_rdata;
      if (mode_q == AVG_MODE_MOVING) begin
         ptr_nx = (s1_ptr == n_m1[PTR_W-1:0]) ? '0 : s1_ptr + 1'b1;
         if (s1_cnt == n_val) begin
            sum_acc = ACC_W'(s1_sum) + ACC_W'(s1_data) - ACC_W'(oldest);
            emit    = 1'b1;
         end else begin
            sum_acc = ACC_W'(s1_sum) + ACC_W'(s1_data);
            cnt_nx  = s1_cnt + 1'b1;
            emit    = (s1_cnt == n_m1);
         end
      end else begin
         sum_acc = ((s1_cnt == '0) ? '0 : ACC_W'(s1_sum)) + ACC_W'(s1_data);
         if (s1_cnt == n_m1) begin
            emit   = 1'b1;
            cnt_nx = '0;
         end else begin
            cnt_nx = s1_cnt + 1'b1;
         end
      end
      sum_nx = sum_acc[SUM_W-1:0];
      avg_nx = avg_of(sum_acc, k_q, i_round);
   end

   // Stage-1 reads take the stage-2 results when both stages hold the same
   // channel, so back-to-back samples see up-to-date state. The history read
   // is forwarded separately when it hits the slot being written.
   always_comb begin
      fwd_state = s2_go && (s1_chan == i_chan);
      rd_ptr    = fwd_state ? ptr_nx : ptr_r[i_chan];
      ram_raddr = {i_chan, rd_ptr};
      ram_we    = s2_go && (mode_q == AVG_MODE_MOVING);
      ram_waddr = {s1_chan, s1_ptr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= i_strobe && !flush_q;
      end
      s1_chan      <= i_chan;
      s1_data      <= i_data;
      s1_sum       <= fwd_state ? sum_nx : sum_r[i_chan];
      s1_cnt       <= fwd_state ? cnt_nx : cnt_r[i_chan];
      s1_ptr       <= rd_ptr;
      s1_hist_fwd  <= ram_we && (ram_waddr == ram_raddr);
      s1_hist_data <= s1_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_q) begin
         for (int c = 0; c < NCHAN; c++) begin
            sum_r[c] <= '0;
            cnt_r[c] <= '0;
            ptr_r[c] <= '0;
         end
      end else if (s2_go) begin
         sum_r[s1_chan] <= sum_nx;
         cnt_r[s1_chan] <= cnt_nx;
         ptr_r[s1_chan] <= ptr_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_strobe   <= 1'b0;
         o_chan     <= '0;
         o_avg_data <= '0;
      end else begin
         o_strobe <= s2_go && emit;
         if (s2_go && emit) begin
            o_chan     <= s1_chan;
            o_avg_data <= avg_nx;
         end
      end
   end

   adc_avg_hist_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_hist (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (s1_data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_adc_avg_mc.sv
// tb_adc_avg_mc
//  Bench for adc_avg_mc. The directed steps cover block and moving averaging,
//  rounding, same-channel back-to-back samples, config flush, mid-block
//  reset and the clamp of i_log2_n. These are followed by randomized
//  segments. Expected outputs come from a per-channel sample-window model
//  that is built from plain queues.
module tb_adc_avg_mc;

   localparam int MAXK = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_strobe;
   logic [1:0]  i_chan;
   logic [11:0] i_data;
   logic [2:0]  i_log2_n;
   logic        i_mode;
   logic        i_round;
   logic        o_strobe;
   logic [1:0]  o_chan;
   logic [11:0] o_avg_data;
   logic        o_cfg_err;

   always #5 clk = ~clk;

   adc_avg_mc dut (
      .clk        (clk),
      .rst        (rst),
      .i_strobe   (i_strobe),
      .i_chan     (i_chan),
      .i_data     (i_data),
      .i_log2_n   (i_log2_n),
      .i_mode     (i_mode),
      .i_round    (i_round),
      .o_strobe   (o_strobe),
      .o_chan     (o_chan),
      .o_avg_data (o_avg_data),
      .o_cfg_err  (o_cfg_err)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Per-channel samples in the current block, or in the moving window
   int win_q [4][$];
   int cur_k;
   bit cur_mode;
   bit cur_round;

   // Expectation for the sample one tick ahead in the pipeline
   bit prev_valid;
   int prev_chan;
   int prev_data;
   int hold_chan;
   int hold_data;

   int const_vals [4] = '{100, 200, 300, 4095};

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int avgRef(input int s);
      int b;
      b = (cur_round && cur_k > 0) ? (1 << (cur_k - 1)) : 0;
      return (s + b) >> cur_k;
   endfunction

   task automatic modelSample(input int ch, input int x, output bit emit, output int val);
      int n;
      int s;
      n = 1 << cur_k;
      s = 0;
      emit = 1'b0;
      val = 0;
      win_q[ch].push_back(x);
      if (cur_mode && win_q[ch].size() > n) begin
         void'(win_q[ch].pop_front());
      end
      if (win_q[ch].size() == n) begin
         for (int i = 0; i < win_q[ch].size(); i++) s += win_q[ch][i];
         emit = 1'b1;
         val = avgRef(s);
         if (!cur_mode) win_q[ch].delete();
      end
   endtask

   task automatic clearModel();
      for (int c = 0; c < 4; c++) win_q[c].delete();
   endtask

   // One clock tick: drive inputs, step the model, and check the outputs
   // after the edge against the sample that was strobed one tick earlier.
   task automatic applyStimulus(input bit stb, input int ch, input int x);
      bit e;
      int v;
      e = 1'b0;
      v = 0;
      i_strobe = stb;
      i_chan   = 2'(ch);
      i_data   = 12'(x);
      if (stb) modelSample(ch, x, e, v);
      @(posedge clk);
      #1;
      checkOutput("o_strobe", 32'(o_strobe), 32'(prev_valid));
      if (prev_valid) begin
         hold_chan = prev_chan;
         hold_data = prev_data;
      end
      checkOutput("o_chan", 32'(o_chan), hold_chan);
      checkOutput("o_avg_data", 32'(o_avg_data), hold_data);
      checkOutput("o_cfg_err", 32'(o_cfg_err), 32'(i_log2_n > 3'd4));
      prev_valid = e;
      prev_chan  = ch;
      prev_data  = v;
      i_strobe   = 1'b0;
   endtask

   task automatic feed(input int ch, input int x);
      applyStimulus(1'b1, ch, x);
   endtask

   task automatic drain();
      repeat (3) applyStimulus(1'b0, 0, 0);
   endtask

   task automatic doReset(input int cycles);
      rst = 1'b1;
      i_strobe = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         checkOutput("rst_strobe", 32'(o_strobe), 0);
         checkOutput("rst_chan", 32'(o_chan), 0);
         checkOutput("rst_data", 32'(o_avg_data), 0);
         checkOutput("rst_cfg_err", 32'(o_cfg_err), 0);
      end
      rst = 1'b0;
      clearModel();
      prev_valid = 1'b0;
      hold_chan = 0;
      hold_data = 0;
   endtask

   // The change cycle and the flush cycle both carry no strobe
   task automatic setConfig(input int log2n, input bit mode);
      int  k_new;
      bit  changed;
      k_new   = (log2n > MAXK) ? MAXK : log2n;
      changed = (k_new != cur_k) || (mode != cur_mode);
      i_log2_n = 3'(log2n);
      i_mode   = mode;
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      cur_k    = k_new;
      cur_mode = mode;
      if (changed) clearModel();
   endtask

   // One idle tick lets the last strobed sample finish under the old rounding
   task automatic setRound(input bit r);
      applyStimulus(1'b0, 0, 0);
      i_round   = r;
      cur_round = r;
   endtask

   initial begin
      i_strobe = 1'b0;
      i_chan   = '0;
      i_data   = '0;
      i_log2_n = 3'd2;
      i_mode   = 1'b0;
      i_round  = 1'b0;
      cur_k    = 2;
      cur_mode = 1'b0;
      cur_round = 1'b0;
      prev_valid = 1'b0;
      prev_chan = 0;
      prev_data = 0;
      hold_chan = 0;
      hold_data = 0;
      doReset(2);

      // Block k=2 on ch0, truncate then round
      feed(0, 10); feed(0, 20); feed(0, 30); feed(0, 42);
      drain();
      checkOutput("t1_trunc", 32'(o_avg_data), 25);
      checkOutput("t1_chan", 32'(o_chan), 0);
      setRound(1'b1);
      feed(0, 10); feed(0, 20); feed(0, 30); feed(0, 42);
      drain();
      checkOutput("t1_round", 32'(o_avg_data), 26);
      setRound(1'b0);

      // Block k=3, round-robin constants including full scale
      setConfig(3, 1'b0);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) feed(c, const_vals[c]);
      drain();
      checkOutput("t2_chan", 32'(o_chan), 3);
      checkOutput("t2_full_scale", 32'(o_avg_data), 4095);

      // Moving k=1 on ch1
      setConfig(1, 1'b1);
      feed(1, 4); feed(1, 8); feed(1, 12); feed(1, 16);
      drain();
      checkOutput("t3_last", 32'(o_avg_data), 14);
      setRound(1'b1);
      feed(1, 4); feed(1, 9);
      drain();
      checkOutput("t3_round", 32'(o_avg_data), 7);
      setRound(1'b0);

      // Moving k=2, then block k=2, back-to-back on ch2
      setConfig(2, 1'b1);
      for (int i = 1; i <= 8; i++) feed(2, i);
      drain();
      checkOutput("t4_moving", 32'(o_avg_data), 6);
      setConfig(2, 1'b0);
      for (int i = 1; i <= 8; i++) feed(2, i);
      drain();
      checkOutput("t4_block", 32'(o_avg_data), 6);

      // Config change mid-block, then reset mid-block
      feed(0, 5); feed(0, 6); feed(0, 7);
      setConfig(1, 1'b0);
      feed(0, 8); feed(0, 10);
      drain();
      checkOutput("t5_after_flush", 32'(o_avg_data), 9);
      setConfig(2, 1'b0);
      feed(1, 40); feed(1, 40); feed(1, 40); feed(1, 40);
      doReset(1);
      feed(1, 1); feed(1, 2); feed(1, 3); feed(1, 6);
      drain();
      checkOutput("t5_restart", 32'(o_avg_data), 3);

      // Out-of-range exponent clamps to 16-sample blocks
      setConfig(7, 1'b0);
      checkOutput("t6_cfg_err_set", 32'(o_cfg_err), 1);
      for (int i = 0; i < 16; i++) feed(3, i * 10);
      drain();
      checkOutput("t6_clamped", 32'(o_avg_data), 75);
      setConfig(2, 1'b0);
      checkOutput("t6_cfg_err_clr", 32'(o_cfg_err), 0);

      // Randomized segments against the model
      for (int seg = 0; seg < 8; seg++) begin
         int top_ch;
         setConfig(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         setRound(1'($urandom_range(0, 1)));
         top_ch = (seg % 2 == 1) ? 1 : 3;
         for (int t = 0; t < 70; t++) begin
            if ($urandom_range(0, 3) != 0) begin
               feed(int'($urandom_range(0, top_ch)),
                    ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095)));
            end else if ($urandom_range(0, 15) == 0) begin
               setRound(1'($urandom_range(0, 1)));
            end else begin
               applyStimulus(1'b0, 0, 0);
            end
         end
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
